// File: rtl/clk_ena_sched_pkg.sv
// Shared types for the clock-enable scheduler: config FSM states, captured
// config request and the channel-index width helper.
package clk_ena_sched_pkg;

  // Captured request fields are sized for the widest build; the top truncates.
  localparam int CFG_CH_W  = 8;
  localparam int CFG_PER_W = 32;

  typedef enum logic [1:0] {IDLE, PEND, WAIT} cfg_st_e;

  typedef struct packed {
    logic [CFG_CH_W-1:0]  ch;
    logic                 run;
    logic [CFG_PER_W-1:0] period;
  } cfg_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_ena_chan.sv
// One enable channel: period register, down-counter and run flag, advanced on
// base ticks; boundary = running with counter at zero.
module clk_ena_chan #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             tk,
  input  logic             load_start,
  input  logic             load_stop,
  input  logic             reload_new,
  input  logic [PER_W-1:0] new_period,
  output logic             bnd,
  output logic             ch_ena,
  output logic             ch_run
);

  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per;

  assign bnd = ch_run && (cnt == '0);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt    <= '0;
      per    <= '0;
      ch_run <= 1'b0;
      ch_ena <= 1'b0;
    end else if (sclr) begin
      cnt    <= '0;
      per    <= '0;
      ch_run <= 1'b0;
      ch_ena <= 1'b0;
    end else if (load_stop) begin
      cnt    <= '0;
      ch_run <= 1'b0;
      ch_ena <= 1'b0;
    end else if (load_start) begin
      per    <= new_period;
      cnt    <= new_period - 1'b1;
      ch_run <= 1'b1;
      ch_ena <= 1'b0;
    end else begin
      ch_ena <= tk && bnd;
      if (tk && ch_run) begin
        if (cnt == '0) begin
          // The boundary pulse above used the old period; only the reload switches.
          if (reload_new) begin
            per <= new_period;
            cnt <= new_period - 1'b1;
          end else begin
            cnt <= per - 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_ena_sched.sv
// Multi-channel clock-enable scheduler: base prescaler, CH period channels and
// a config FSM that applies period changes only at channel boundaries.
module clk_ena_sched
  import clk_ena_sched_pkg::*;
#(
  parameter int CLK_DIV = 5,
  parameter int CH      = 4,
  parameter int PER_W   = 16
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ch_w(CH)-1:0]   cfg_ch,
  input  logic                  cfg_run,
  input  logic [PER_W-1:0]      cfg_period,
  output logic                  base_ena,
  output logic [CH-1:0]         ch_ena,
  output logic [CH-1:0]         ch_run
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] PCNT_TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0]    pcnt;
  logic             tk;
  cfg_st_e          st;
  cfg_t             cfg_q;
  logic             req_stop;
  logic [PER_W-1:0] req_per;
  logic [CH-1:0]    sel, bnd, ld_start, ld_stop, rl_new;

  assign tk        = (pcnt == '0);
  assign cfg_ready = (st == IDLE);
  assign req_per   = cfg_q.period[PER_W-1:0];
  assign req_stop  = !cfg_q.run || (cfg_q.period == '0);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      pcnt     <= PCNT_TOP;
      base_ena <= 1'b0;
    end else if (sclr) begin
      pcnt     <= PCNT_TOP;
      base_ena <= 1'b0;
    end else begin
      pcnt     <= tk ? PCNT_TOP : pcnt - 1'b1;
      base_ena <= tk;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign sel[c]      = (int'(cfg_q.ch) == c);
    assign ld_stop[c]  = (st == PEND) && sel[c] && req_stop;
    assign ld_start[c] = (st == PEND) && sel[c] && !req_stop && !ch_run[c];
    assign rl_new[c]   = (st == WAIT) && sel[c] && tk && bnd[c];

    clk_ena_chan #(.PER_W(PER_W)) u_chan (
      .clk        (clk),
      .aclr_n     (aclr_n),
      .sclr       (sclr),
      .tk         (tk),
      .load_start (ld_start[c]),
      .load_stop  (ld_stop[c]),
      .reload_new (rl_new[c]),
      .new_period (req_per),
      .bnd        (bnd[c]),
      .ch_ena     (ch_ena[c]),
      .ch_run     (ch_run[c])
    );
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      st    <= IDLE;
      cfg_q <= '0;
    end else if (sclr) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE: if (cfg_valid) begin
          cfg_q <= '{ch: CFG_CH_W'(cfg_ch), run: cfg_run, period: CFG_PER_W'(cfg_period)};
          // Out-of-range channel requests are consumed and dropped.
          if (int'(cfg_ch) < CH) st <= PEND;
        end
        PEND: st <= (req_stop || !(|(ch_run & sel))) ? IDLE : WAIT;
        WAIT: if (tk && |(bnd & sel)) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ena_sched.sv
// Randomized scoreboard bench for clk_ena_sched against a tick-count model.
module tb_clk_ena_sched;
  localparam int CLK_DIV = 5;
  localparam int CH      = 4;
  localparam int PER_W   = 16;

  logic clk = 1'b0, aclr_n = 1'b0, sclr = 1'b0;
  logic cfg_valid = 1'b0, cfg_run = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [PER_W-1:0] cfg_period = '0;
  logic cfg_ready, base_ena;
  logic [CH-1:0] ch_ena, ch_run;

  logic v3 = 1'b0;
  logic [1:0] ch3 = '0;
  logic cfg_ready3, base_ena3;
  logic [2:0] ch_ena3, ch_run3;

  always #5 clk = ~clk;

  clk_ena_sched #(.CLK_DIV(CLK_DIV), .CH(CH), .PER_W(PER_W)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_run(cfg_run), .cfg_period(cfg_period),
    .base_ena(base_ena), .ch_ena(ch_ena), .ch_run(ch_run));

  clk_ena_sched #(.CLK_DIV(CLK_DIV), .CH(3), .PER_W(PER_W)) dut3 (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .cfg_valid(v3), .cfg_ready(cfg_ready3),
    .cfg_ch(ch3), .cfg_run(cfg_run), .cfg_period(cfg_period),
    .base_ena(base_ena3), .ch_ena(ch_ena3), .ch_run(ch_run3));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s at %0t: wait expired", nm, $time);
  endtask

  // Reference model: everything is counted in base ticks since the last restart.
  typedef struct {int e_no; logic [CH-1:0] msk;} pulse_t;
  pulse_t pq[$];
  int  edge_no = 0, since = 0, tick = 0;
  bit  m_run[CH], m_pend[CH];
  int  m_per[CH], m_next[CH], m_newp[CH];
  bit  busy = 0, req_new = 0, r_run = 0;
  int  r_ch = 0, r_per = 0;
  logic exp_base = 1'b0, exp_ready = 1'b1;
  logic [CH-1:0] exp_run = '0;

  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      since = 0; busy = 0; req_new = 0; pq.delete();
      for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_pend[c] = 0; end
      exp_base = 1'b0; exp_ready = 1'b1; exp_run = '0;
    end else begin
      logic [CH-1:0] mask;
      bit acc, rstop;
      edge_no++;
      mask  = '0;
      acc   = !busy && cfg_valid;
      rstop = req_new && (!r_run || r_per == 0);
      if (sclr) begin
        since = 0; busy = 0; req_new = 0;
        for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_pend[c] = 0; end
        exp_base = 1'b0;
      end else begin
        since++;
        exp_base = (since % CLK_DIV == 0);
        if (exp_base) tick++;
        for (int c = 0; c < CH; c++)
          if (m_run[c] && exp_base && tick == m_next[c] && !(rstop && r_ch == c)) begin
            mask[c] = 1'b1;
            if (m_pend[c]) begin m_per[c] = m_newp[c]; m_pend[c] = 0; busy = 0; end
            m_next[c] = tick + m_per[c];
          end
        if (req_new) begin
          req_new = 0;
          if (rstop) begin
            m_run[r_ch] = 0; busy = 0;
          end else if (!m_run[r_ch]) begin
            m_run[r_ch] = 1; m_per[r_ch] = r_per; m_next[r_ch] = tick + r_per; busy = 0;
          end else begin
            m_pend[r_ch] = 1; m_newp[r_ch] = r_per;
          end
        end
        if (acc && int'(cfg_ch) < CH) begin
          r_ch = int'(cfg_ch); r_run = cfg_run; r_per = int'(cfg_period);
          busy = 1; req_new = 1;
        end
      end
      exp_ready = !busy;
      for (int c = 0; c < CH; c++) exp_run[c] = m_run[c];
      if (mask != '0) pq.push_back('{e_no: edge_no, msk: mask});
    end
  end

  // Monitor: state outputs every cycle, pulses popped from the scoreboard.
  always @(negedge clk) begin
    check("base_ena", base_ena, exp_base);
    check("ch_run", ch_run, exp_run);
    check("cfg_ready", cfg_ready, exp_ready);
    check("ch3_ena_lo", ch_ena3[1:0], 0);
    if (ch_ena != '0) begin
      if (pq.size() == 0) check("ch_ena_spurious", ch_ena, 0);
      else begin
        pulse_t p;
        p = pq.pop_front();
        check("pulse_edge", edge_no, p.e_no);
        check("pulse_mask", ch_ena, p.msk);
      end
    end else if (pq.size() != 0 && pq[0].e_no <= edge_no) begin
      check("pulse_missed", ch_ena, pq[0].msk);
      void'(pq.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int ch, input bit run, input int per);
    int w;
    w = 0;
    @(posedge clk); #2;
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_run = run; cfg_period = PER_W'(per);
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      if (++w > 200) begin timeout("cfg_handshake"); break; end
    end
    @(posedge clk); #2;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #2 aclr_n = 1'b1;

    // Narrow-build instance: channel 3 is out of range and must be dropped.
    idle(2);
    v3 = 1'b1; ch3 = 2'd3; cfg_run = 1'b1; cfg_period = 16'd1;
    @(posedge clk); #2 v3 = 1'b0;
    @(negedge clk);
    check("ch3_oor_ready", cfg_ready3, 1);
    check("ch3_oor_run", ch_run3, 0);
    @(posedge clk); #2 v3 = 1'b1; ch3 = 2'd2;
    @(posedge clk); #2 v3 = 1'b0;
    @(negedge clk);
    check("ch3_pend_ready", cfg_ready3, 0);
    @(negedge clk);
    check("ch3_start_run", ch_run3, 3'b100);
    check("ch3_idle_ready", cfg_ready3, 1);

    send(0, 1, 3);  idle(60);
    send(1, 1, 4);  idle(25);
    send(1, 1, 2);  idle(60);
    send(0, 0, 5);  idle(20);
    send(0, 1, 3);  idle(20);
    send(0, 1, 0);  idle(20);
    send(3, 1, 1);  idle(20);

    // sclr while a period update waits, on a base_ena cycle.
    send(2, 1, 6);
    w = 0;
    forever begin
      @(negedge clk);
      if (ch_ena[2]) break;
      if (++w > 200) begin timeout("ch2_pulse"); break; end
    end
    send(2, 1, 2);
    w = 0;
    forever begin
      @(negedge clk);
      if (!cfg_ready && base_ena) break;
      if (++w > 200) begin timeout("wait_base"); break; end
    end
    sclr = 1'b1;
    @(posedge clk); #2 sclr = 1'b0;
    idle(20);

    // Asynchronous reset pulse mid-operation.
    send(0, 1, 2);  idle(13);
    aclr_n = 1'b0;
    @(posedge clk); #2 aclr_n = 1'b1;
    idle(10);

    for (int i = 0; i < 150; i++) begin
      idle($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        sclr = 1'b1;
        @(posedge clk); #2 sclr = 1'b0;
      end
      send($urandom_range(0, 3), $urandom_range(0, 7) != 0, $urandom_range(0, 6));
    end
    idle(40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
